// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus a 4-state consecutive-sample debounce FSM.
// Define DEBOUNCER_EDGE_PULSE_EN to add the btn_rise / btn_fall pulse outputs.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_db
`ifdef DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic btn_rise,
  output logic btn_fall
`endif
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic sync_ff1;
  (* ASYNC_REG = "TRUE" *) logic sync_ff2;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 db_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= button;
      sync_ff2 <= sync_ff1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STABLE_LOW;
      count  <= '0;
      btn_db <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      btn_db <= db_next;
    end
  end

  // Counter only runs in WAIT states; any bounce drops it back to zero.
  always_comb begin
    state_next = state;
    count_next = '0;
    db_next    = btn_db;
    case (state)
      STABLE_LOW: begin
        if (sync_ff2) begin
          state_next = WAIT_HIGH;
          count_next = ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_ff2) begin
          state_next = STABLE_LOW;
        end else if (count == LAST) begin
          state_next = STABLE_HIGH;
          db_next    = 1'b1;
        end else begin
          count_next = count + ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync_ff2) begin
          state_next = WAIT_LOW;
          count_next = ONE;
        end
      end
      WAIT_LOW: begin
        if (sync_ff2) begin
          state_next = STABLE_HIGH;
        end else if (count == LAST) begin
          state_next = STABLE_LOW;
          db_next    = 1'b0;
        end else begin
          count_next = count + ONE;
        end
      end
      default: begin
        state_next = STABLE_LOW;
        db_next    = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCER_EDGE_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
    end else begin
      btn_rise <= (state == WAIT_HIGH) && (state_next == STABLE_HIGH);
      btn_fall <= (state == WAIT_LOW) && (state_next == STABLE_LOW);
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES = 8.
// A small reference model tracks the expected level during the random bounce phase.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic button;
  logic btn_db;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic btn_rise;
  logic btn_fall;
`endif

  int checks = 0;
  int errors = 0;

  logic m1, m2, mdb, mprev;
  int   mrun;

  button_debouncer #(.DEBOUNCE_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .btn_db(btn_db)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge; the model sees the same inputs the DUT samples.
  task automatic tick();
    mprev = mdb;
    if (rst) begin
      m1 = 0; m2 = 0; mdb = 0; mrun = 0;
    end else begin
      if (m2 != mdb) begin
        mrun++;
        if (mrun == 8) begin
          mdb  = ~mdb;
          mrun = 0;
        end
      end else begin
        mrun = 0;
      end
      m2 = m1;
      m1 = button;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_change(input logic v, input string tag);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk({tag, "_hold"}, btn_db, ~v);
    end
    tick();
    chk({tag, "_edge"}, btn_db, v);
`ifdef DEBOUNCER_EDGE_PULSE_EN
    chk({tag, "_rise"}, btn_rise, v);
    chk({tag, "_fall"}, btn_fall, ~v);
`endif
    tick();
    chk({tag, "_after"}, btn_db, v);
`ifdef DEBOUNCER_EDGE_PULSE_EN
    chk({tag, "_rise0"}, btn_rise, 1'b0);
    chk({tag, "_fall0"}, btn_fall, 1'b0);
`endif
  endtask

  initial begin
    int hi [3];
    int hold;
    int n;
    int db_trans;
    int rises;
    int falls;
    logic pdb;

    m1 = 0; m2 = 0; mdb = 0; mprev = 0; mrun = 0;
    rst = 1'b1;
    button = 1'b1;

    // reset held with button high
    repeat (3) begin
      tick();
      chk("rst_db", btn_db, 1'b0);
`ifdef DEBOUNCER_EDGE_PULSE_EN
      chk("rst_rise", btn_rise, 1'b0);
      chk("rst_fall", btn_fall, 1'b0);
`endif
    end
    rst = 1'b0;
    expect_change(1'b1, "t1");

    // release with bounce
    button = 1'b0;
    repeat (4) begin tick(); chk("t4_b", btn_db, 1'b1); end
    button = 1'b1;
    repeat (2) begin tick(); chk("t4_b", btn_db, 1'b1); end
    button = 1'b0;
    expect_change(1'b0, "t4");

    // clean press
    button = 1'b1;
    expect_change(1'b1, "t2");
    repeat (8) begin tick(); chk("t2_hold", btn_db, 1'b1); end
    button = 1'b0;
    expect_change(1'b0, "t2rel");

    // bounce reject
    hi[0] = 3; hi[1] = 5; hi[2] = 7;
    for (int k = 0; k < 3; k++) begin
      button = 1'b1;
      repeat (hi[k]) begin tick(); chk("t3_rej", btn_db, 1'b0); end
      button = 1'b0;
      repeat (2) begin tick(); chk("t3_rej", btn_db, 1'b0); end
    end
    button = 1'b1;
    expect_change(1'b1, "t3");
    button = 1'b0;
    expect_change(1'b0, "t3rel");

    // reset in the middle of WAIT_HIGH
    button = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("t5_db", btn_db, 1'b0);
    chk("t5_cnt", dut.count == '0, 1'b1);
    rst = 1'b0;
    expect_change(1'b1, "t5");
    button = 1'b0;
    expect_change(1'b0, "t5rel");

    // exactly 7 then exactly 8 synchronized high cycles
    button = 1'b1;
    repeat (7) tick();
    button = 1'b0;
    repeat (14) begin tick(); chk("t6_7", btn_db, 1'b0); end
    button = 1'b1;
    repeat (8) begin tick(); chk("t6_8w", btn_db, 1'b0); end
    button = 1'b0;
    tick();
    chk("t6_8pre", btn_db, 1'b0);
    tick();
    chk("t6_8", btn_db, 1'b1);
    repeat (20) tick();
    chk("t6_8rel", btn_db, 1'b0);

    // random bounce stream against the reference model
    n = 0; db_trans = 0; rises = 0; falls = 0;
    pdb = btn_db;
    while (n < 1000) begin
      button = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      repeat (hold) begin
        tick();
        n++;
        chk("rnd_db", btn_db, mdb);
        if (btn_db != pdb) db_trans++;
        pdb = btn_db;
`ifdef DEBOUNCER_EDGE_PULSE_EN
        chk("rnd_rise", btn_rise, mdb & ~mprev);
        chk("rnd_fall", btn_fall, ~mdb & mprev);
        chk("rnd_excl", btn_rise & btn_fall, 1'b0);
        if (btn_rise) rises++;
        if (btn_fall) falls++;
`endif
      end
    end
`ifdef DEBOUNCER_EDGE_PULSE_EN
    chk("rnd_pulse_cnt", (rises + falls) == db_trans, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Conditions a raw, bouncing push-button or slide-switch input from the Arty board into a clean, single-clock-domain level. It sits directly upstream of the inverter / LED logic in the practicum designs. Its `btn_db` output is the signal those gates consume in place of the raw pin. The block provides synchronization, a consecutive-sample debounce counter and a 4-state FSM.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles the synchronized input must differ from `btn_db` before `btn_db` toggles. This is 10 ms at 100 MHz. Legal range is 2 to 2^24.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1), counter width. It is derived and must not be overridden.

Ports:
- clk  input  1  system clock, 100 MHz on board; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  1  raw asynchronous pin, bouncing.
- btn_db  output  1  debounced level, registered.
- btn_rise  output  1  one-cycle pulse on `btn_db` 0->1. Present only with the macro.
- btn_fall  output  1  one-cycle pulse on `btn_db` 1->0. Present only with the macro.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high, sampled only on the `clk` rising edge.
- Reset values: sync_ff1 = 0, sync_ff2 = 0, count = 0, state = STABLE_LOW, btn_db = 0, btn_rise = 0, btn_fall = 0.
- Synchronizer: two-flop chain button -> sync_ff1 -> sync_ff2. `sync_ff2` is the only signal used downstream. The ASYNC_REG attribute goes on both flops.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW, sync_ff2 = 1: go to WAIT_HIGH, count <= 1.
- STABLE_LOW, sync_ff2 = 0: stay, count <= 0.
- WAIT_HIGH, sync_ff2 = 0: return to STABLE_LOW, count <= 0. This is the bounce-reject case.
- WAIT_HIGH, sync_ff2 = 1 and count == DEBOUNCE_CYCLES-1: go to STABLE_HIGH, btn_db <= 1, count <= 0.
- WAIT_HIGH, sync_ff2 = 1 otherwise: count <= count+1.
- STABLE_HIGH and WAIT_LOW mirror the above with polarities swapped. btn_db <= 0 on entry to STABLE_LOW from WAIT_LOW.
- `btn_db` is a registered state output: it equals 1 iff state is STABLE_HIGH or WAIT_LOW.
- Latency: `button` is sampled at edge E0 and held stable. `btn_db` changes after edge E0+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges including E0.
- Glitch rejection: any `sync_ff2` excursion shorter than DEBOUNCE_CYCLES cycles never changes `btn_db`. The counter restarts from 1 on the next excursion and does not accumulate.
- Counter:
  - never exceeds DEBOUNCE_CYCLES-1;
  - no wrap-around is possible;
  - is 0 in both STABLE states.
- Reset mid-WAIT: the count is discarded. The state returns to STABLE_LOW on the reset edge, regardless of the `button` level. If `button` is held high through reset, `btn_db` rises DEBOUNCE_CYCLES+2 edges after `rst` deasserts.
- Illegal or unreachable state encodings recover to STABLE_LOW on the next edge (default branch).

Optional Feature:
- Macro: DEBOUNCER_EDGE_PULSE_EN.
- Defined:
  - `btn_rise` and `btn_fall` ports exist and are registered.
  - `btn_rise` = 1 for exactly the one cycle in which `btn_db` first reads 1.
  - `btn_fall` = 1 for exactly the one cycle in which `btn_db` first reads 0.
  - Both are generated from the same FSM transitions, so they are coincident with the `btn_db` change and add zero extra latency.
  - They are never asserted together; both are 0 during and after reset.
- Undefined: the ports and their logic are absent. `btn_db` behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 8 and a 10 ns clk.
1. Reset: rst = 1 for 3 cycles with `button` = 1 -> btn_db = 0, btn_rise = 0, btn_fall = 0 during reset. After release, btn_db = 1 exactly 10 edges after the first edge with rst = 0.
2. Clean press: button 0->1 held 200 ns -> btn_db rises 10 edges after the first sampling edge. With the macro, btn_rise is high for exactly 1 cycle coincident with that change.
3. Bounce reject: button toggles 1/0 with high times of 3, 5 and 7 cycles (gaps of 2 cycles) -> btn_db stays 0 throughout. A final 8+ cycle high then raises btn_db on schedule.
4. Release with bounce: from btn_db = 1, button low for 4 cycles, high for 2, then low held -> btn_db falls 10 edges after the final low is sampled. btn_fall pulses once.
5. Reset mid-WAIT: button high for 5 cycles, then rst = 1 for 1 cycle, button still high -> btn_db = 0, count = 0 after reset. btn_db rises 10 edges after rst deasserts.
6. Boundary: button high for exactly 7 synchronized cycles, then low -> no change. Exactly 8 synchronized cycles -> btn_db = 1. Long random bounce stream (1000 cycles) -> btn_rise and btn_fall counts match btn_db transitions and are never asserted together.
